// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-frame writer.
// Bus levels for every (state, quarter) pair live here so the FSM only tracks position.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam int         FRAME_BYTES        = 6;
    localparam logic [7:0] REG_PTR_START      = 8'h00;
    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

    typedef logic [1:0] quarter_t;
    localparam quarter_t Q0 = 2'd0;
    localparam quarter_t Q1 = 2'd1;
    localparam quarter_t Q2 = 2'd2;
    localparam quarter_t Q3 = 2'd3;

    // Returns {scl, sda_low}; sda_low=1 pulls SDA down, otherwise SDA is released.
    function automatic logic [1:0] bus_level(input state_t st, input quarter_t q, input logic bit_val);
        logic scl;
        logic sda_low;
        scl     = 1'b1;
        sda_low = 1'b0;
        case (st)
            ST_START: begin
                scl     = (q != Q3);
                sda_low = q[1];
            end
            ST_BYTE: begin
                scl     = q[1];
                sda_low = !bit_val;
            end
            ST_ACK: begin
                scl     = q[1];
                sda_low = 1'b0;
            end
            ST_STOP: begin
                scl     = (q != Q0);
                sda_low = !q[1];
            end
            default: begin
                scl     = 1'b1;
                sda_low = 1'b0;
            end
        endcase
        return {scl, sda_low};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-cycle tick every DIV clocks, held at zero while clear is high
// so the first quarter of a frame starts exactly on the cycle after start.
module i2c_tick_gen #(
    parameter int DIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = !clear && (cnt_reg == CW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_reg_writer.sv
// I2C master writing {addr+W, 0x00, y0, y1, speed, trig} in one transaction per start pulse.
// Define I2C_MASTER_ACK_CHECK_EN to sample ACK bits and abort to STOP on a NACK.
module i2c_master_reg_writer
    import i2c_pkg::*;
#(
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         I2C_FREQ   = 100_000,
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_y0,
    input  logic [7:0] tx_y1,
    input  logic [7:0] tx_speed,
    input  logic [7:0] tx_trig,
    output logic       SCL,
    inout  wire        SDA,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int         DIV       = CLK_FREQ / (4 * I2C_FREQ);
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    state_t     state_reg, state_next;
    quarter_t   quarter_reg, quarter_next;
    logic [2:0] bit_reg, bit_next;
    logic [2:0] byte_reg, byte_next;
    logic       ack_err_reg, ack_err_next;
    logic       scl_reg, sda_low_reg, busy_reg, done_reg;
    logic       tick, tick_clear, accept, next_bit;

    logic [7:0] tx_in      [4];
    logic [7:0] frame_byte [FRAME_BYTES];

    assign tx_in[0] = tx_y0;
    assign tx_in[1] = tx_y1;
    assign tx_in[2] = tx_speed;
    assign tx_in[3] = tx_trig;

    assign accept     = (state_reg == ST_IDLE) && start;
    assign tick_clear = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

    // Bytes 0/1 are constants; the four data bytes are captured only on an accepted start.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_BYTES; gi++) begin : g_frame
            if (gi == 0) begin : g_addr
                assign frame_byte[gi] = {SLAVE_ADDR, 1'b0};
            end else if (gi == 1) begin : g_ptr
                assign frame_byte[gi] = REG_PTR_START;
            end else begin : g_data
                logic [7:0] data_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        data_reg <= '0;
                    end else if (accept) begin
                        data_reg <= tx_in[gi-2];
                    end
                end
                assign frame_byte[gi] = data_reg;
            end
        end
    endgenerate

    i2c_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state_reg;
        quarter_next = quarter_reg;
        bit_next     = bit_reg;
        byte_next    = byte_reg;
        ack_err_next = ack_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_START;
                    quarter_next = Q0;
                    ack_err_next = 1'b0;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: begin
                if (tick) begin
`ifdef I2C_MASTER_ACK_CHECK_EN
                    if (state_reg == ST_ACK && quarter_reg == Q2 && SDA) begin
                        ack_err_next = 1'b1;
                    end
`endif
                    if (quarter_reg != Q3) begin
                        quarter_next = quarter_reg + 2'd1;
                    end else begin
                        quarter_next = Q0;
                        case (state_reg)
                            ST_START: begin
                                state_next = ST_BYTE;
                                bit_next   = 3'd7;
                                byte_next  = 3'd0;
                            end
                            ST_BYTE: begin
                                if (bit_reg == 3'd0) begin
                                    state_next = ST_ACK;
                                end else begin
                                    bit_next = bit_reg - 3'd1;
                                end
                            end
                            ST_ACK: begin
                                // ack_err_reg can only be set when ACK checking is compiled in
                                if (byte_reg == LAST_BYTE || ack_err_reg) begin
                                    state_next = ST_STOP;
                                end else begin
                                    state_next = ST_BYTE;
                                    byte_next  = byte_reg + 3'd1;
                                    bit_next   = 3'd7;
                                end
                            end
                            ST_STOP: state_next = ST_DONE;
                            default: state_next = state_reg;
                        endcase
                    end
                end
            end
        endcase
    end

    assign next_bit = frame_byte[byte_next][bit_next];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            quarter_reg <= Q0;
            bit_reg     <= '0;
            byte_reg    <= '0;
            ack_err_reg <= 1'b0;
            scl_reg     <= 1'b1;
            sda_low_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg                <= state_next;
            quarter_reg              <= quarter_next;
            bit_reg                  <= bit_next;
            byte_reg                 <= byte_next;
            ack_err_reg              <= ack_err_next;
            {scl_reg, sda_low_reg}   <= bus_level(state_next, quarter_next, next_bit);
            busy_reg                 <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_reg                 <= (state_next == ST_DONE);
        end
    end

    assign SCL     = scl_reg;
    assign SDA     = sda_low_reg ? 1'b0 : 1'bz;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign ack_err = ack_err_reg;

endmodule

// File: tb/tb_i2c_master_reg_writer.sv
// Directed bench: DIV=10 master with a bus monitor / ACKing slave, plus a default-parameter
// master on its own bus with no slave (NACK on every ACK bit).
module tb_i2c_master_reg_writer;

`ifdef I2C_MASTER_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n, rst_d, start, start_d, ack_on;
    logic [7:0] tx_y0, tx_y1, tx_speed, tx_trig;
    logic       scl_m, busy_m, done_m, ack_err_m;
    logic       scl_d, busy_d, done_d, ack_err_d;
    logic       slave_drive = 1'b0;
    wire        sda_m;
    wire        sda_d;

    pullup (sda_m);
    pullup (sda_d);
    assign sda_m = slave_drive ? 1'b0 : 1'bz;

    i2c_master_reg_writer #(
        .CLK_FREQ   (4_000_000),
        .I2C_FREQ   (100_000),
        .SLAVE_ADDR (7'h50)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .tx_y0    (tx_y0),
        .tx_y1    (tx_y1),
        .tx_speed (tx_speed),
        .tx_trig  (tx_trig),
        .SCL      (scl_m),
        .SDA      (sda_m),
        .busy     (busy_m),
        .done     (done_m),
        .ack_err  (ack_err_m)
    );

    i2c_master_reg_writer dut_def (
        .clk      (clk),
        .reset    (rst_d),
        .start    (start_d),
        .tx_y0    (tx_y0),
        .tx_y1    (tx_y1),
        .tx_speed (tx_speed),
        .tx_trig  (tx_trig),
        .SCL      (scl_d),
        .SDA      (sda_d),
        .busy     (busy_d),
        .done     (done_d),
        .ack_err  (ack_err_d)
    );

    // Bus monitor and slave model for the DIV=10 master.
    logic       scl_q = 1'b1, sda_q = 1'b1, stop_seen = 1'b0;
    int         mon_bit = 0, n_bytes = 0, rise_n = 0, rise_t1 = 0, rise_t2 = 0;
    logic [7:0] mon_sh = 8'h00;
    logic [7:0] mon_bytes [16];

    always @(negedge clk) begin
        scl_q <= scl_m;
        sda_q <= sda_m;
        if (scl_m && scl_q && sda_q && !sda_m) begin
            mon_bit   <= 0;
            n_bytes   <= 0;
            stop_seen <= 1'b0;
            rise_n    <= 0;
        end else if (scl_m && scl_q && !sda_q && sda_m) begin
            stop_seen <= 1'b1;
        end else if (scl_m && !scl_q) begin
            rise_n <= rise_n + 1;
            if (rise_n == 0) rise_t1 <= cyc;
            if (rise_n == 1) rise_t2 <= cyc;
            if (mon_bit < 8) mon_sh <= {mon_sh[6:0], sda_m};
            if (mon_bit == 7 && n_bytes < 16) begin
                mon_bytes[n_bytes] <= {mon_sh[6:0], sda_m};
                n_bytes            <= n_bytes + 1;
            end
            mon_bit <= (mon_bit >= 8) ? 0 : mon_bit + 1;
        end
        if (!scl_m && scl_q) slave_drive <= ack_on && (mon_bit == 8);
    end

    int   def_c0 = 0, def_done_at = 0;
    logic def_ack_at_done = 1'b0;
    always @(negedge clk) begin
        if (done_d && def_done_at == 0) begin
            def_done_at     <= cyc - def_c0;
            def_ack_at_done <= ack_err_d;
        end
    end

    int n_cmp = 0, n_mis = 0, c0 = 0, at = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        c0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int t);
        t = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (done_m) begin
                t = cyc - c0;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] exp_b [6];
        exp_b[0] = 8'hA0;
        exp_b[1] = 8'h00;
        exp_b[2] = d0;
        exp_b[3] = d1;
        exp_b[4] = d2;
        exp_b[5] = d3;
        check({tag, "_nbytes"}, n_bytes, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_byte%0d", tag, i), mon_bytes[i], exp_b[i]);
        end
        check({tag, "_stop"}, stop_seen, 1);
        check({tag, "_ack_err"}, ack_err_m, 0);
        $display("frame %s: done@%0d bytes %h %h %h %h %h %h", tag, at,
                 mon_bytes[0], mon_bytes[1], mon_bytes[2], mon_bytes[3], mon_bytes[4], mon_bytes[5]);
    endtask

    initial begin
        rst_n = 1'b0; rst_d = 1'b0; start = 1'b0; start_d = 1'b0; ack_on = 1'b1;
        tx_y0 = 8'h12; tx_y1 = 8'h34; tx_speed = 8'h05; tx_trig = 8'h01;
        repeat (3) @(negedge clk);
        check("rst_scl", scl_m, 1);
        check("rst_sda", sda_m, 1);
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_ack_err", ack_err_m, 0);
        rst_n = 1'b1; rst_d = 1'b1;
        @(negedge clk);

        // Default-parameter master runs alongside everything below.
        start_d = 1'b1; def_c0 = cyc;
        @(negedge clk);
        start_d = 1'b0;
        check("def_busy_c1", busy_d, 1);

        // Frame A, with an ignored start and tx_y0 change mid-frame.
        launch();
        check("a_busy_c1", busy_m, 1);
        check("a_scl_c1", scl_m, 1);
        check("a_sda_c1", sda_m, 1);
        while (cyc - c0 < 800) @(negedge clk);
        tx_y0 = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("a_busy_after_restart", busy_m, 1);
        wait_done(3000, at);
        check("a_done_cycle", at, 2241);
        check("a_busy_in_done", busy_m, 0);
        check("a_scl_period", rise_t2 - rise_t1, 40);
        check_frame("A", 8'h12, 8'h34, 8'h05, 8'h01);

        // start in the DONE cycle is dropped; the next cycle launches frame B.
        start = 1'b1;
        @(negedge clk);
        check("done_start_ignored_busy", busy_m, 0);
        check("done_start_ignored_done", done_m, 0);
        tx_y0 = 8'hAB; tx_y1 = 8'hCD; tx_speed = 8'hEF; tx_trig = 8'h7E;
        launch();
        check("b_busy_c1", busy_m, 1);
        tx_y0 = 8'h00; tx_y1 = 8'h00; tx_speed = 8'h00; tx_trig = 8'h00;
        wait_done(3000, at);
        check("b_done_cycle", at, 2241);
        check_frame("B", 8'hAB, 8'hCD, 8'hEF, 8'h7E);

        // Frame C abandoned by reset mid-byte (y1 bit6, quarter 1).
        tx_y0 = 8'h12; tx_y1 = 8'h34; tx_speed = 8'h05; tx_trig = 8'h01;
        @(negedge clk);
        launch();
        while (cyc - c0 < 1180) @(negedge clk);
        check("c_pre_rst_scl", scl_m, 0);
        check("c_pre_rst_sda", sda_m, 0);
        #1 rst_n = 1'b0;
        #1;
        check("c_rst_scl", scl_m, 1);
        check("c_rst_sda", sda_m, 1);
        check("c_rst_busy", busy_m, 0);
        check("c_rst_done", done_m, 0);
        check("c_rst_ack_err", ack_err_m, 0);
        $display("frame C: reset at cycle %0d", cyc - c0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame D: clean frame after reset.
        launch();
        wait_done(3000, at);
        check("d_done_cycle", at, 2241);
        check_frame("D", 8'h12, 8'h34, 8'h05, 8'h01);

        // Frame E: slave NACKs everything.
        ack_on = 1'b0;
        @(negedge clk);
        launch();
        wait_done(3000, at);
        check("e_done_cycle", at, ACK_CHK ? 441 : 2241);
        check("e_ack_err", ack_err_m, ACK_CHK);
        check("e_nbytes", n_bytes, ACK_CHK ? 1 : 6);
        check("e_byte0", mon_bytes[0], 8'hA0);
        check("e_stop", stop_seen, 1);
        $display("frame E: done@%0d ack_err=%0b bytes=%0d", at, ack_err_m, n_bytes);

        // Frame F: accepted start clears ack_err.
        ack_on = 1'b1;
        @(negedge clk);
        launch();
        check("f_ack_err_c1", ack_err_m, 0);
        wait_done(3000, at);
        check("f_done_cycle", at, 2241);
        check_frame("F", 8'h12, 8'h34, 8'h05, 8'h01);

        // Default-parameter frame with no ACKing slave.
        for (int k = 0; k < 60000 && def_done_at == 0; k++) @(negedge clk);
        check("def_done_cycle", def_done_at, ACK_CHK ? 11001 : 56001);
        check("def_ack_err", def_ack_at_done, ACK_CHK);
        check("def_busy_end", busy_d, 0);
        $display("frame DEF: done@%0d ack_err=%0b", def_done_at, def_ack_at_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/i2c_master_reg_writer.md
# i2c_master_reg_writer

I2C master that writes a four-register frame (y0, y1, speed, trig) to the board's I2C slave register file. On a `start` pulse it latches four data bytes and issues one write transaction on SCL/SDA: START, address+W, register pointer 0x00, four data bytes, STOP. The slave auto-increments its register pointer. It sits on the sender board and drives the same SCL/SDA pair that the slave board receives.

## Interface
- `CLK_FREQ`, 100_000_000, system clock in Hz
- `I2C_FREQ`, 100_000, SCL frequency in Hz
- `SLAVE_ADDR`, 7'h50, 7-bit target address
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; ignored while `busy`
- `tx_y0`  in  8  byte for slave reg0
- `tx_y1`  in  8  byte for slave reg1
- `tx_speed`  in  8  byte for slave reg2
- `tx_trig`  in  8  byte for slave reg3
- `SCL`  out  1  I2C clock, push-pull
- `SDA`  inout  1  I2C data, open-drain (drive 0 or Z; external pull-up)
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse at end of frame
- `ack_err`  out  1  sticky NACK flag; cleared on the next accepted `start`

## Operation
- Quarter tick: `DIV = CLK_FREQ/(4*I2C_FREQ)`, default 250 clocks. Each bit is four quarters q0–q3.
- Frame bytes, MSB first: `{SLAVE_ADDR,1'b0}`, 0x00, tx_y0, tx_y1, tx_speed, tx_trig. Byte counter runs 0..5.
- States: IDLE → START → BYTE → ACK → (BYTE if more bytes, else STOP) → DONE → IDLE.
- IDLE: SCL=1, SDA=Z. An accepted `start` latches the four tx bytes and clears `ack_err`. Input changes during a frame have no effect.
- START quarters: q0, q1 SDA=1, SCL=1; q2 SDA=0, SCL=1; q3 SDA=0, SCL=0.
- BYTE bit: q0 SCL=0 and SDA takes the bit (1 → Z); q1 SCL=0; q2, q3 SCL=1. Eight bits per byte.
- ACK bit: SDA=Z throughout. SCL follows the data-bit pattern. SDA is sampled on the last clock of q2; a sampled 1 is a NACK.
- STOP quarters: q0 SDA=0, SCL=0; q1 SDA=0, SCL=1; q2, q3 SDA=Z, SCL=1.
- DONE: lasts one cycle, `done`=1. `busy` drops in the same cycle. A `start` in the DONE cycle is not accepted; one is accepted the cycle after.
- Boundary behaviour:
  - `start` while busy: ignored, no queuing.
  - Reset asserted mid-frame: SCL=1, SDA=Z, all flags 0 immediately (asynchronous). The bus is abandoned mid-byte and the slave recovers on the next START.

## Timing
- Reset values: SCL=1, SDA=Z, busy=0, done=0, ack_err=0. The tick counter and state are cleared.
- `busy` rises 1 clock after `start`. START phase q0 begins in that cycle.
- Full frame = START (1 bit time) + 6×9 bits + STOP (1 bit time) = 56 bit times = 56×4×DIV clocks. Default: 56,000 clocks, 560 µs.
- `done` is asserted in cycle 56×4×DIV+1 after the accepted `start`.
- After a NACK abort: STOP begins at the next bit boundary following the ACK bit.

## Configuration
- `I2C_MASTER_ACK_CHECK_EN` defined:
  - A NACK on any ACK bit sets `ack_err`, skips the remaining bytes and goes to STOP, then DONE.
  - `done` still pulses.
- Not defined:
  - ACK bits are clocked but SDA is not sampled.
  - The full frame is always sent; `ack_err` is tied 0.

## Structure
- Package `i2c_pkg`:
  - state enum
  - `FRAME_BYTES = 6`
  - `REG_PTR_START = 8'h00`
  - default `SLAVE_ADDR`
  - quarter-phase encoding
- Sub-module `i2c_tick_gen`: parameterised divider producing the one-cycle quarter tick. It is held cleared while IDLE, so the first quarter is aligned to `start`.

## Test plan
- Default params, slave model always ACKs, tx = 0x12/0x34/0x05/0x01, `start` pulse.
  - Bus decodes as bytes 0xA0, 0x00, 0x12, 0x34, 0x05, 0x01, framed by START/STOP.
  - `done` at cycle 56,001; ack_err=0.
- Macro on, slave NACKs the address.
  - ack_err=1; STOP follows the first ACK bit.
  - No further bytes; `done` at (1+9+1)×1000+1 = 11,001.
- Macro off, slave NACKs every byte.
  - All 6 bytes are sent; ack_err=0; `done` at 56,001.
- `start` pulsed again at cycle 20,000 with tx_y0=0xFF.
  - Ignored; frame still carries 0x12.
  - A `start` in the DONE cycle is also ignored.
  - A `start` one cycle after DONE launches a new frame.
- Reset asserted at cycle 30,000 (mid-byte).
  - Same cycle: SCL=1, SDA=Z, busy=0.
  - After release, a new `start` produces a correct full frame.
- CLK_FREQ=4_000_000, I2C_FREQ=100_000 (DIV=10).
  - Frame length = 2,240 clocks; SCL period = 40 clocks.
